// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, MUL sequencer state type, control width.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] MUL_OP  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiply step: retires BITS_PER_CYCLE multiplier bits per call.
module mul_step #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    output logic [DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0] mcand_next,
    output logic [DATA_W-1:0] mplier_next
);

    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] mplier_sh;

    // Partial product of the low multiplier chunk, weighted bit by bit.
    always_comb begin
        partial   = '0;
        mplier_sh = mplier;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_sh[0]) partial = partial + (mcand << i);
            mplier_sh = mplier_sh >> 1;
        end
        acc_next    = acc + partial;
        mcand_next  = mcand << BITS_PER_CYCLE;
        mplier_next = mplier >> BITS_PER_CYCLE;
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle MUL controller for the EX stage: stalls, iterates shift-add, presents result one cycle.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  ex_valid,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  stall_o,
    output logic                  result_valid_o,
    output logic [DATA_W-1:0]     result_o
);

    localparam int unsigned N_STEPS = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);

    mul_state_t        state, state_next;
    logic [DATA_W-1:0] acc, acc_n, mcand, mcand_n, mplier, mplier_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] acc_step, mcand_step, mplier_step;
    logic              start_c, last_step_c;

    mul_step #(
        .DATA_W        (DATA_W),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_next   (acc_step),
        .mcand_next (mcand_step),
        .mplier_next(mplier_step)
    );

    assign start_c = ex_valid && (alu_control == MUL_OP) && !flush;

`ifdef MUL_EARLY_TERM_EN
    assign last_step_c = (cnt == CNT_W'(N_STEPS - 1)) || (mplier_step == '0);
`else
    assign last_step_c = (cnt == CNT_W'(N_STEPS - 1));
`endif

    // Stall is combinational so the pipeline freezes in the same cycle the MUL is seen.
    assign stall_o = arst_n && (((state == IDLE) && start_c) || (state == BUSY));

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        acc_n      = acc;
        mcand_n    = mcand;
        mplier_n   = mplier;
        cnt_n      = cnt;
        case (state)
            IDLE: begin
                if (start_c) begin
                    acc_n      = '0;
                    mcand_n    = op_a;
                    mplier_n   = op_b;
                    cnt_n      = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    acc_n    = acc_step;
                    mcand_n  = mcand_step;
                    mplier_n = mplier_step;
                    cnt_n    = cnt + CNT_W'(1);
                    if (last_step_c) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= IDLE;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            cnt            <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            state          <= state_next;
            acc            <= acc_n;
            mcand          <= mcand_n;
            mplier         <= mplier_n;
            cnt            <= cnt_n;
            result_valid_o <= (state_next == DONE);
            // Capture the final step's sum as it enters DONE; held until the next product.
            if ((state == BUSY) && (state_next == DONE)) result_o <= acc_step;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer against a cycle-count/product reference model.
module tb_alu_mul_sequencer;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              arst_n;
    logic              ex_valid;
    logic [3:0]        alu_control;
    logic              flush;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall_o;
    logic              result_valid_o;
    logic [DATA_W-1:0] result_o;

    int tests;
    int fails;
    logic [DATA_W-1:0] last_result;

    alu_mul_sequencer #(
        .DATA_W        (DATA_W),
        .BITS_PER_CYCLE(1)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .ex_valid      (ex_valid),
        .alu_control   (alu_control),
        .flush         (flush),
        .op_a          (op_a),
        .op_b          (op_b),
        .stall_o       (stall_o),
        .result_valid_o(result_valid_o),
        .result_o      (result_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of BUSY cycles the model expects for multiplier b.
    function automatic int model_steps(input logic [DATA_W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int k;
        k = 1;
        while (k < 32 && (b >> k) != 0) k++;
        return k;
`else
        return 32;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] model_product(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[DATA_W-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic exp_stall,
                                 input logic exp_valid, input logic [DATA_W-1:0] exp_res);
        tests++;
        if (stall_o !== exp_stall) begin
            fails++;
            $display("FAIL %s stall_o: got %b expected %b at %0t", name, stall_o, exp_stall, $time);
        end
        tests++;
        if (result_valid_o !== exp_valid) begin
            fails++;
            $display("FAIL %s result_valid_o: got %b expected %b at %0t", name, result_valid_o, exp_valid, $time);
        end
        tests++;
        if (result_o !== exp_res) begin
            fails++;
            $display("FAIL %s result_o: got %h expected %h at %0t", name, result_o, exp_res, $time);
        end
    endtask

    // Present a MUL at the current cycle (cycle 0) and check every cycle through DONE.
    task automatic run_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input string name);
        int steps;
        logic [DATA_W-1:0] prod;
        steps = model_steps(b);
        prod  = model_product(a, b);
        ex_valid    = 1'b1;
        alu_control = 4'd8;
        flush       = 1'b0;
        op_a        = a;
        op_b        = b;
        #1;
        check_outputs({name, "_c0"}, 1'b1, 1'b0, last_result);
        for (int c = 1; c <= steps + 1; c++) begin
            next_cycle();
            if (c <= steps) begin
                check_outputs({name, "_busy"}, 1'b1, 1'b0, last_result);
            end else begin
                last_result = prod;
                check_outputs({name, "_done"}, 1'b0, 1'b1, prod);
            end
        end
    endtask

    task automatic go_idle();
        next_cycle();
        ex_valid = 1'b0;
        alu_control = 4'd0;
        #1;
        check_outputs("idle_after", 1'b0, 1'b0, last_result);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        ex_valid = 1'b0;
        alu_control = 4'd0;
        flush = 1'b0;
        op_a = '0;
        op_b = '0;
        last_result = '0;
        #1;
        check_outputs("reset_hold", 1'b0, 1'b0, '0);
        next_cycle();
        next_cycle();
        arst_n = 1'b1;
        next_cycle();
        check_outputs("reset_release", 1'b0, 1'b0, '0);
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd6, "basic_7x6");
        go_idle();
    endtask

    task automatic test_reset_mid();
        ex_valid = 1'b1;
        alu_control = 4'd8;
        op_a = 32'd9;
        op_b = 32'hFFFF_FFFF;
        for (int c = 1; c <= 10; c++) next_cycle();
        arst_n = 1'b0;
        last_result = '0;
        #1;
        check_outputs("reset_mid_async", 1'b0, 1'b0, '0);
        ex_valid = 1'b0;
        next_cycle();
        arst_n = 1'b1;
        next_cycle();
        check_outputs("reset_mid_idle", 1'b0, 1'b0, '0);
        run_mul(32'd11, 32'd13, "post_reset");
        go_idle();
    endtask

    task automatic test_wrap();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap_ffxff");
        go_idle();
        run_mul(32'h8000_0000, 32'd2, "wrap_8x2");
        go_idle();
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] b;
`ifdef MUL_EARLY_TERM_EN
        b = 32'h8000_0005;
`else
        b = 32'd5;
`endif
        run_mul(32'd1234, 32'd5678, "pre_flush");
        next_cycle();
        ex_valid = 1'b1;
        alu_control = 4'd8;
        op_a = 32'd3;
        op_b = b;
        for (int c = 1; c <= 10; c++) next_cycle();
        flush = 1'b1;
        #1;
        check_outputs("flush_cycle", 1'b1, 1'b0, last_result);
        next_cycle();
        flush = 1'b0;
        ex_valid = 1'b0;
        #1;
        check_outputs("flush_after", 1'b0, 1'b0, last_result);
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            check_outputs("flush_quiet", 1'b0, 1'b0, last_result);
        end
        run_mul(32'd2, 32'd2, "post_flush");
        go_idle();
    endtask

    task automatic test_non_mul();
        logic [3:0] code;
        for (int c = 0; c < 12; c++) begin
            code = 4'($urandom_range(0, 15));
            if (code == 4'd8) code = 4'd2;
            ex_valid = 1'b1;
            alu_control = code;
            op_a = $urandom;
            op_b = $urandom;
            #1;
            check_outputs("non_mul", 1'b0, 1'b0, last_result);
            next_cycle();
        end
        ex_valid = 1'b0;
        alu_control = 4'd8;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_outputs("mul_not_valid", 1'b0, 1'b0, last_result);
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        run_mul(32'd3, 32'd3, "b2b_first");
        next_cycle();
        run_mul(32'd4, 32'd4, "b2b_second");
        go_idle();
    endtask

    task automatic test_early_term();
        run_mul(32'd5, 32'd3, "early_5x3");
        go_idle();
        run_mul(32'hDEAD_BEEF, 32'd0, "early_bzero");
        go_idle();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(0, 31);
            run_mul(a, b, "random");
            if (i % 2 == 0) next_cycle();
            else go_idle();
        end
        go_idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_wrap();
        test_flush();
        test_non_mul();
        test_back_to_back();
        test_early_term();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller and iterative datapath for the MUL ALU operation (alu_control code 4'd8) in the EX stage.
- Detects a valid MUL in EX, stalls the pipeline, runs a shift-add multiply over several cycles, then presents the result for one cycle.
- Sits beside the single-cycle ALU; the EX-stage result mux selects result_o when result_valid_o is high.

Parameters:
DATA_W, 32, operand and result width.
BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle; must divide DATA_W.
N_STEPS, DATA_W/BITS_PER_CYCLE, derived localparam; number of BUSY cycles.

Ports:
clk  input  1  clock; all state updates on the rising edge.
arst_n  input  1  asynchronous active-low reset.
ex_valid  input  1  EX stage holds a valid instruction.
alu_control  input  4  ALU control code from alu_control; 4'd8 is MUL.
flush  input  1  EX-stage flush (branch/exception); aborts the multiply.
op_a  input  DATA_W  multiplicand.
op_b  input  DATA_W  multiplier.
stall_o  output  1  freeze IF/ID/EX; combinational.
result_valid_o  output  1  result_o holds a completed product this cycle.
result_o  output  DATA_W  low DATA_W bits of op_a*op_b.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - state=IDLE; accumulator, multiplicand, multiplier and step counter cleared to 0.
  - result_o=0, result_valid_o=0, stall_o=0.
  - Reset asserted mid-BUSY discards the operation immediately.
- States: IDLE, BUSY, DONE.
- start = ex_valid & (alu_control==MUL_OP) & ~flush, evaluated in IDLE only.
- IDLE:
  - On start: latch op_a and op_b, clear accumulator and counter, go to BUSY.
  - stall_o = start (combinational, same cycle).
- BUSY, each cycle:
  - Add (multiplicand masked by the low BITS_PER_CYCLE multiplier bits, weighted) to the accumulator.
  - Shift multiplicand left by BITS_PER_CYCLE; shift multiplier right by BITS_PER_CYCLE; increment counter.
  - When the counter reaches N_STEPS-1, go to DONE.
  - stall_o=1.
- DONE, exactly one cycle:
  - result_valid_o=1, stall_o=0; the pipeline advances at the end of this cycle.
  - Return to IDLE unconditionally. The same MUL, still in EX during DONE, must not restart.
- Timing: start in cycle 0, BUSY in cycles 1..N_STEPS, DONE in cycle N_STEPS+1. stall_o is high for N_STEPS+1 cycles.
- Arithmetic:
  - Unsigned shift-add; only the low DATA_W bits are kept, so overflow wraps (RISC-V MUL semantics; the signed low half is identical).
  - The accumulator is DATA_W wide.
- result_o holds its last value until the next DONE. result_valid_o is low outside DONE.
- flush in BUSY: go to IDLE next cycle, stall_o drops with the flush cycle's edge, no DONE, result_o unchanged. flush in DONE is ignored.
- Non-MUL codes, or ex_valid=0: no effect; the block stays in IDLE.
- Back-to-back MULs: the second MUL reaches EX the cycle after DONE and starts from IDLE normally.

Optional Feature:
MUL_EARLY_TERM_EN
- Defined: BUSY moves to DONE after any step that leaves the shifted multiplier equal to zero (or at counter N_STEPS-1, whichever comes first). Stall length becomes data-dependent; the result is identical.
- Undefined: fixed N_STEPS BUSY cycles always.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants (AND..SLT, MUL_OP=4'd8).
  - mul_state_t enum {IDLE, BUSY, DONE}.
  - ALU_CTRL_W=4.
- One natural sub-module, mul_step: combinational single step. Inputs: accumulator, multiplicand, multiplier chunk. Outputs: next accumulator, next multiplicand, next multiplier.
- The FSM, counter and flush/stall logic stay in alu_mul_sequencer.

Test Plan:
1. Reset: arst_n low at cycle 10 of a multiply -> stall_o=0, result_valid_o=0, result_o=0 with no clock edge; IDLE after release.
2. Basic: op_a=7, op_b=6, alu_control=8, ex_valid=1, DATA_W=32 -> stall_o high cycles 0..32; result_valid_o=1 and result_o=42 in cycle 33 only.
3. Wrap: 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001; 0x80000000*2 -> result_o=0x00000000.
4. Flush: start 3*5, flush=1 in cycle 10 -> no result_valid_o, stall_o low from cycle 11, result_o retains its prior value; a following MUL 2*2 gives 4.
5. Non-MUL and back-to-back: alu_control=2 with ex_valid=1 -> stall_o never high. Two consecutive MULs 3*3 then 4*4 -> 9 in cycle 33, 16 in cycle 67; no restart during DONE.
6. With MUL_EARLY_TERM_EN: 5*3 -> BUSY cycles 1..2, result_valid_o=1 with 15 in cycle 3. op_b=0 -> DONE in cycle 2 with result_o=0.
